jtcop_mapsel_ctl: RTL
=====================

// Module: jtcop_mapsel_ctl
// PURPOSE
//  Parametrised bank-map selector for Data East BAC06 protection windows. A pulse
//  counter, advanced by read strobes and cleared by write strobes, selects one of
//  2^SELW maps. The selected map is a loadable table that routes each address window to
//  one of NCS chip selects. It sits beside the main CPU decoder: the decoder supplies the
//  strobes and the window index, and this block returns registered chip selects.
// PARAMETERS
//  SELW  2  map-select counter width; 2^SELW maps
//  WINW  3  window index width; 2^WINW windows per map
//  NCS   8  number of one-hot chip-select outputs; CSW=$clog2(NCS) (localparam)
// PORTS
//  clk        in   1              system clock
//  rst        in   1              synchronous reset, active high
//  ASn        in   1              CPU address strobe, active low
//  region_cs  in   1              access falls inside the map-controlled region
//  win        in   WINW           window index within the region (decoded address bits)
//  inc_cs     in   1              count-up strobe (level); counted on its rising edge
//  clr_cs     in   1              count-clear strobe (level); acts on its rising edge
//  mode       in   1              0: counter wraps; 1: counter saturates at all-ones
//  tbl_we     in   1              table write enable
//  tbl_addr   in   SELW+WINW      table entry address, {sel,win}
//  tbl_din    in   CSW+1          table entry data, {valid,cs_index}
//  mapsel     out  SELW           map in effect for the current bus cycle
//  cs         out  NCS            one-hot chip select, registered
//  miss       out  1              region access hit an invalid entry, registered
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): premap=0, mapsel=0, inc_l=0, clr_l=0, cs=0, miss=0.
//   All table entries load {valid=1, cs_index=win mod NCS} for every sel (identity map).
//   Reset wins over every other event in the same cycle, including tbl_we.
//  Edge detect: inc_l<=inc_cs and clr_l<=clr_cs every cycle. inc_rise=inc_cs&~inc_l, and
//   clr_rise likewise. An inc_cs held high across reset release counts once.
//  premap update, in priority order:
//   - clr_rise: premap<=0. If inc_rise occurs in the same cycle, the clear wins.
//   - inc_rise, mode=0: premap<=premap+1, wrapping from all-ones to 0.
//   - inc_rise, mode=1: premap<=premap+1 only while premap!=all-ones, else it holds.
//  mapsel<=premap on every cycle with ASn=1. While ASn=0, mapsel holds, so the map is
//   stable for the whole bus cycle. A count made during a cycle takes effect on the next.
//  Lookup, registered with 1-cycle latency:
//   - e=table[{mapsel,win}] is read combinationally from the current-cycle values.
//   - If ASn=0 & region_cs & e.valid: cs<=1<<e.cs_index and miss<=0.
//   - If ASn=0 & region_cs & !e.valid: cs<=0 and miss<=1.
//   - Otherwise: cs<=0 and miss<=0. cs drops one cycle after ASn rises.
//   - If e.cs_index>=NCS, the result is cs=0 and miss=1.
//  Table write: with tbl_we=1, table[tbl_addr]<=tbl_din at the clk edge.
//   A lookup in the same cycle to the same entry uses the old contents; the new value is
//   visible the next cycle. Writes are allowed at any time, including mid bus cycle.
//  Reset mid bus cycle: cs, miss and mapsel are 0 on the cycle after the reset edge.
//   Lookup resumes with sel=0 once rst falls.
//  Width rules: all counter arithmetic is modulo 2^SELW. There is no other state.
// TESTING
//  1 After reset, ASn=0, region_cs=1, win=3 -> cs=8'h08 one clk later, miss=0, mapsel=0.
//  2 Three inc_cs pulses, with ASn=0 throughout -> mapsel stays 0. After ASn=1 for one
//    clk -> mapsel=3.
//  3 mode=0, four inc pulses -> premap=0. mode=1, four inc pulses -> premap=3.
//    Then clr pulse -> premap=0.
//  4 inc_cs and clr_cs rise on the same clk, with premap=2 -> premap=0.
//  5 Write tbl_addr={2'd1,3'd2}, tbl_din={1,3'd5}. One inc, ASn=1, then access win=2
//    -> cs=8'h20. Rewrite with valid=0, repeat the access -> cs=0, miss=1.
//  6 Assert rst for 1 clk during an active access with cs=8'h20 -> cs=0, miss=0,
//    mapsel=0. The table is back to identity: sel=1, win=2 -> cs=8'h04.

Source files
------------

// File: rtl/jtcop_mapsel_ctl.sv
// BAC06 bank-map selector: a strobe-driven counter picks one of 2^SELW loadable
// window->chip-select maps; the lookup result is registered as one-hot cs / miss.
module jtcop_mapsel_ctl #(
  parameter int SELW = 2,
  parameter int WINW = 3,
  parameter int NCS  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ASn,
  input  logic                   region_cs,
  input  logic [WINW-1:0]        win,
  input  logic                   inc_cs,
  input  logic                   clr_cs,
  input  logic                   mode,
  input  logic                   tbl_we,
  input  logic [SELW+WINW-1:0]   tbl_addr,
  input  logic [$clog2(NCS):0]   tbl_din,
  output logic [SELW-1:0]        mapsel,
  output logic [NCS-1:0]         cs,
  output logic                   miss
);
  localparam int CSW  = $clog2(NCS);
  localparam int ADW  = SELW + WINW;
  localparam int NENT = 2**ADW;

  logic [SELW-1:0] premap;
  logic            inc_l, clr_l;
  logic            inc_rise, clr_rise;
  logic [CSW:0]    tbl [NENT];
  logic [CSW:0]    ent;
  logic [CSW-1:0]  ent_idx;
  logic            ent_ok;

  assign inc_rise = inc_cs & ~inc_l;
  assign clr_rise = clr_cs & ~clr_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      premap <= '0;
      mapsel <= '0;
      inc_l  <= 1'b0;
      clr_l  <= 1'b0;
    end else begin
      inc_l <= inc_cs;
      clr_l <= clr_cs;
      if (clr_rise)
        premap <= '0;
      else if (inc_rise && (!mode || premap != '1))
        premap <= premap + 1'b1;
      // map is frozen while the bus cycle is in progress
      if (ASn)
        mapsel <= premap;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NENT; i++) begin
      if (rst)
        tbl[i] <= {1'b1, CSW'((i % (2**WINW)) % NCS)};
      else if (tbl_we && tbl_addr == ADW'(i))
        tbl[i] <= tbl_din;
    end
  end

  assign ent     = tbl[{mapsel, win}];
  assign ent_idx = ent[CSW-1:0];
  // an index past the last chip select is treated like an invalid entry
  assign ent_ok  = ent[CSW] && (32'(ent_idx) < NCS);

  always_ff @(posedge clk) begin
    if (rst) begin
      cs   <= '0;
      miss <= 1'b0;
    end else if (!ASn && region_cs) begin
      cs   <= ent_ok ? (NCS'(1) << ent_idx) : '0;
      miss <= ~ent_ok;
    end else begin
      cs   <= '0;
      miss <= 1'b0;
    end
  end
endmodule
